// File: rtl/mmu_tlb_xlat.sv
// rtl/mmu_tlb_xlat.sv - registered VA->PA translation with kseg0/kseg1 windows and fully-associative TLB
module mmu_tlb_xlat #(
    parameter int ENTRIES = 8,
    parameter int ASID_W  = 8,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              k0_cached,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_vaddr,
    input  logic [ASID_W-1:0] req_asid,
    input  logic              req_write,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_paddr,
    output logic              rsp_cached,
    output logic [1:0]        rsp_exc,
    input  logic              tlb_we,
    input  logic [IDX_W-1:0]  tlb_index,
    input  logic [19:0]       tlb_vpn,
    input  logic [ASID_W-1:0] tlb_asid,
    input  logic              tlb_g,
    input  logic [19:0]       tlb_pfn,
    input  logic              tlb_v,
    input  logic              tlb_d,
    input  logic              tlb_c,
    output logic [15:0]       miss_count
);

    localparam logic [1:0] EXC_NONE  = 2'b00;
    localparam logic [1:0] EXC_MISS  = 2'b01;
    localparam logic [1:0] EXC_INV   = 2'b10;
    localparam logic [1:0] EXC_CLEAN = 2'b11;

    logic [ENTRIES-1:0] present_q, present_d;
    logic [19:0]        vpn_q  [ENTRIES];
    logic [19:0]        vpn_d  [ENTRIES];
    logic [ASID_W-1:0]  asid_q [ENTRIES];
    logic [ASID_W-1:0]  asid_d [ENTRIES];
    logic [19:0]        pfn_q  [ENTRIES];
    logic [19:0]        pfn_d  [ENTRIES];
    logic [ENTRIES-1:0] g_q, g_d, v_q, v_d, d_q, d_d, c_q, c_d;

    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_paddr_q, rsp_paddr_d;
    logic        rsp_cached_q, rsp_cached_d;
    logic [1:0]  rsp_exc_q, rsp_exc_d;
    logic [15:0] miss_count_q, miss_count_d;

    logic             accept;
    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic [31:0]      xl_paddr;
    logic             xl_cached;
    logic [1:0]       xl_exc;

    assign req_ready  = !rsp_valid_q || rsp_ready;
    assign accept     = req_valid && req_ready;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_paddr  = rsp_paddr_q;
    assign rsp_cached = rsp_cached_q;
    assign rsp_exc    = rsp_exc_q;
    assign miss_count = miss_count_q;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (present_q[i] && vpn_q[i] == req_vaddr[31:12] &&
                (g_q[i] || asid_q[i] == req_asid)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        xl_paddr  = 32'h0;
        xl_cached = 1'b0;
        xl_exc    = EXC_NONE;
        if (req_vaddr[31:29] == 3'b101) begin
            xl_paddr = req_vaddr - 32'hA000_0000;
        end else if (req_vaddr[31:29] == 3'b100) begin
            xl_paddr  = req_vaddr - 32'h8000_0000;
            xl_cached = k0_cached;
        end else if (hit) begin
            xl_paddr  = {pfn_q[hit_idx], req_vaddr[11:0]};
            xl_cached = c_q[hit_idx];
            if (!v_q[hit_idx]) begin
                xl_exc = EXC_INV;
            end else if (req_write && !d_q[hit_idx]) begin
                xl_exc = EXC_CLEAN;
            end
        end else begin
            xl_exc = EXC_MISS;
        end
    end

    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_paddr_d  = rsp_paddr_q;
        rsp_cached_d = rsp_cached_q;
        rsp_exc_d    = rsp_exc_q;
        miss_count_d = miss_count_q;
        if (accept) begin
            rsp_valid_d  = 1'b1;
            rsp_paddr_d  = xl_paddr;
            rsp_cached_d = xl_cached;
            rsp_exc_d    = xl_exc;
            if (xl_exc == EXC_MISS && miss_count_q != 16'hFFFF) begin
                miss_count_d = miss_count_q + 16'd1;
            end
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_comb begin
        present_d = present_q;
        vpn_d     = vpn_q;
        asid_d    = asid_q;
        pfn_d     = pfn_q;
        g_d       = g_q;
        v_d       = v_q;
        d_d       = d_q;
        c_d       = c_q;
        if (tlb_we) begin
            present_d[tlb_index] = 1'b1;
            vpn_d[tlb_index]     = tlb_vpn;
            asid_d[tlb_index]    = tlb_asid;
            pfn_d[tlb_index]     = tlb_pfn;
            g_d[tlb_index]       = tlb_g;
            v_d[tlb_index]       = tlb_v;
            d_d[tlb_index]       = tlb_d;
            c_d[tlb_index]       = tlb_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            present_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_paddr_q  <= 32'h0;
            rsp_cached_q <= 1'b0;
            rsp_exc_q    <= EXC_NONE;
            miss_count_q <= 16'h0;
        end else begin
            present_q    <= present_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_paddr_q  <= rsp_paddr_d;
            rsp_cached_q <= rsp_cached_d;
            rsp_exc_q    <= rsp_exc_d;
            miss_count_q <= miss_count_d;
        end
    end

    // Entry payload needs no reset; the present flags gate every use of it.
    always_ff @(posedge clk) begin
        vpn_q  <= vpn_d;
        asid_q <= asid_d;
        pfn_q  <= pfn_d;
        g_q    <= g_d;
        v_q    <= v_d;
        d_q    <= d_d;
        c_q    <= c_d;
    end

endmodule

// File: tb/tb_mmu_tlb_xlat.sv
// tb/tb_mmu_tlb_xlat.sv - directed self-checking bench for mmu_tlb_xlat
module tb_mmu_tlb_xlat;

    logic        clk = 1'b0;
    logic        rst, k0_cached, req_valid, req_ready, req_write;
    logic [31:0] req_vaddr;
    logic [7:0]  req_asid;
    logic        rsp_valid, rsp_ready, rsp_cached;
    logic [31:0] rsp_paddr;
    logic [1:0]  rsp_exc;
    logic        tlb_we, tlb_g, tlb_v, tlb_d, tlb_c;
    logic [2:0]  tlb_index;
    logic [19:0] tlb_vpn, tlb_pfn;
    logic [7:0]  tlb_asid;
    logic [15:0] miss_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mmu_tlb_xlat dut (
        .clk(clk), .rst(rst), .k0_cached(k0_cached),
        .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
        .req_asid(req_asid), .req_write(req_write),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_paddr(rsp_paddr),
        .rsp_cached(rsp_cached), .rsp_exc(rsp_exc),
        .tlb_we(tlb_we), .tlb_index(tlb_index), .tlb_vpn(tlb_vpn), .tlb_asid(tlb_asid),
        .tlb_g(tlb_g), .tlb_pfn(tlb_pfn), .tlb_v(tlb_v), .tlb_d(tlb_d), .tlb_c(tlb_c),
        .miss_count(miss_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rsp_chk(input string tag, input logic [31:0] pa, input logic c, input logic [1:0] e);
        chk({tag, ".valid"}, {31'h0, rsp_valid}, 32'h1);
        chk({tag, ".paddr"}, rsp_paddr, pa);
        chk({tag, ".cached"}, {31'h0, rsp_cached}, {31'h0, c});
        chk({tag, ".exc"}, {30'h0, rsp_exc}, {30'h0, e});
    endtask

    task automatic do_req(input logic [31:0] va, input logic [7:0] asid, input logic wr);
        req_valid = 1'b1;
        req_vaddr = va;
        req_asid  = asid;
        req_write = wr;
        step();
    endtask

    task automatic tlb_write(input logic [2:0] idx, input logic [19:0] vpn, input logic [7:0] asid,
                             input logic g, input logic [19:0] pfn, input logic v, input logic d,
                             input logic c);
        req_valid = 1'b0;
        tlb_we    = 1'b1;
        tlb_index = idx;
        tlb_vpn   = vpn;
        tlb_asid  = asid;
        tlb_g     = g;
        tlb_pfn   = pfn;
        tlb_v     = v;
        tlb_d     = d;
        tlb_c     = c;
        step();
        tlb_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; k0_cached = 1'b0; req_valid = 1'b0; req_vaddr = 32'h0; req_asid = 8'h0;
        req_write = 1'b0; rsp_ready = 1'b1; tlb_we = 1'b0; tlb_index = 3'd0; tlb_vpn = 20'h0;
        tlb_asid = 8'h0; tlb_g = 1'b0; tlb_pfn = 20'h0; tlb_v = 1'b0; tlb_d = 1'b0; tlb_c = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("reset.valid", {31'h0, rsp_valid}, 32'h0);
        chk("reset.paddr", rsp_paddr, 32'h0);
        chk("reset.cached", {31'h0, rsp_cached}, 32'h0);
        chk("reset.exc", {30'h0, rsp_exc}, 32'h0);
        chk("reset.miss", {16'h0, miss_count}, 32'h0);
        chk("reset.ready", {31'h0, req_ready}, 32'h1);

        do_req(32'hA000_1234, 8'h0, 1'b0);
        rsp_chk("kseg1", 32'h0000_1234, 1'b0, 2'b00);

        k0_cached = 1'b1;
        do_req(32'h9FFF_FFFC, 8'h0, 1'b0);
        rsp_chk("kseg0.top", 32'h1FFF_FFFC, 1'b1, 2'b00);
        k0_cached = 1'b0;
        do_req(32'h8000_0000, 8'h0, 1'b0);
        rsp_chk("kseg0.base", 32'h0000_0000, 1'b0, 2'b00);

        do_req(32'h7FFF_FFFF, 8'h0, 1'b0);
        rsp_chk("bound.7fff", 32'h0, 1'b0, 2'b01);
        do_req(32'hC000_0000, 8'h0, 1'b0);
        rsp_chk("bound.c000", 32'h0, 1'b0, 2'b01);
        chk("miss.after2", {16'h0, miss_count}, 32'd2);

        tlb_write(3'd3, 20'h00400, 8'd5, 1'b0, 20'h12345, 1'b1, 1'b0, 1'b1);
        chk("idle.valid", {31'h0, rsp_valid}, 32'h0);
        do_req(32'h0040_0ABC, 8'd5, 1'b0);
        rsp_chk("hit.e3", 32'h1234_5ABC, 1'b1, 2'b00);
        do_req(32'h0040_0ABC, 8'd6, 1'b0);
        rsp_chk("asid.miss", 32'h0, 1'b0, 2'b01);
        do_req(32'h0040_0ABC, 8'd5, 1'b1);
        rsp_chk("clean.wr", 32'h1234_5ABC, 1'b1, 2'b11);

        tlb_write(3'd6, 20'h00500, 8'd9, 1'b1, 20'h66666, 1'b1, 1'b1, 1'b0);
        tlb_write(3'd1, 20'h00500, 8'd5, 1'b0, 20'h11111, 1'b1, 1'b1, 1'b1);
        do_req(32'h0050_0010, 8'd5, 1'b1);
        rsp_chk("multi.low", 32'h1111_1010, 1'b1, 2'b00);
        do_req(32'h0050_0010, 8'd7, 1'b0);
        rsp_chk("global.e6", 32'h6666_6010, 1'b0, 2'b00);

        tlb_we = 1'b1; tlb_index = 3'd1; tlb_vpn = 20'h00500; tlb_asid = 8'd5; tlb_g = 1'b0;
        tlb_pfn = 20'h22222; tlb_v = 1'b1; tlb_d = 1'b1; tlb_c = 1'b1;
        do_req(32'h0050_0020, 8'd5, 1'b0);
        tlb_we = 1'b0;
        rsp_chk("wr.same.old", 32'h1111_1020, 1'b1, 2'b00);
        do_req(32'h0050_0020, 8'd5, 1'b0);
        rsp_chk("wr.next.new", 32'h2222_2020, 1'b1, 2'b00);

        tlb_write(3'd0, 20'h00700, 8'd0, 1'b1, 20'h77777, 1'b0, 1'b1, 1'b1);
        do_req(32'h0070_0444, 8'd3, 1'b0);
        rsp_chk("invalid", 32'h7777_7444, 1'b1, 2'b10);

        do_req(32'hA000_0100, 8'd0, 1'b0);
        rsp_ready = 1'b0;
        req_vaddr = 32'hA000_0200;
        #1;
        chk("bp.ready0", {31'h0, req_ready}, 32'h0);
        tlb_we = 1'b1; tlb_index = 3'd2; tlb_vpn = 20'hA0000; tlb_g = 1'b1; tlb_pfn = 20'h55555;
        step();
        tlb_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rsp_chk("bp.hold", 32'h0000_0100, 1'b0, 2'b00);
            chk("bp.ready", {31'h0, req_ready}, 32'h0);
            if (i < 2) step();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp.release.ready", {31'h0, req_ready}, 32'h1);
        step();
        rsp_chk("bp.next", 32'h0000_0200, 1'b0, 2'b00);
        do_req(32'hA000_0300, 8'd0, 1'b0);
        rsp_chk("bp.after", 32'h0000_0300, 1'b0, 2'b00);
        chk("miss.before.sat", {16'h0, miss_count}, 32'd3);

        for (int i = 0; i < 65540; i++) begin
            do_req(32'h0000_1000, 8'd0, 1'b0);
        end
        rsp_chk("sat.rsp", 32'h0, 1'b0, 2'b01);
        chk("sat.count", {16'h0, miss_count}, 32'h0000_FFFF);

        do_req(32'h0040_0ABC, 8'd5, 1'b0);
        rsp_chk("pre.rst.hit", 32'h1234_5ABC, 1'b1, 2'b00);
        rsp_ready = 1'b0;
        step();
        chk("pre.rst.held", {31'h0, rsp_valid}, 32'h1);
        rst = 1'b1;
        rsp_ready = 1'b1;
        step();
        rst = 1'b0;
        chk("rst.valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst.miss", {16'h0, miss_count}, 32'h0);
        do_req(32'h0040_0ABC, 8'd5, 1'b0);
        rsp_chk("rst.tlb.empty", 32'h0, 1'b0, 2'b01);
        chk("rst.miss1", {16'h0, miss_count}, 32'd1);

        req_valid = 1'b0;
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mmu_tlb_xlat.md
Name: mmu_tlb_xlat

Overview:
- Registered virtual-to-physical address translation stage that sits between a CPU request port (fetch or load/store) and its cache.
- Handles the fixed kseg0 and kseg1 windows directly.
- All other addresses are translated through a parametrised fully-associative TLB with ASID and global matching.
- Reports a cacheability bit and an exception code per request, with valid/ready flow control on both sides and a saturating miss counter.

Parameters:
- ENTRIES, 8, number of TLB entries (power of two, ≥2)
- ASID_W, 8, address-space identifier width
- IDX_W, $clog2(ENTRIES), TLB index width (derived; do not override)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- k0_cached  in  1  cacheability applied to kseg0 accesses
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_vaddr  in  32  virtual address
- req_asid  in  ASID_W  current ASID
- req_write  in  1  1 = store access
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_paddr  out  32  physical address
- rsp_cached  out  1  1 = cacheable
- rsp_exc  out  2  00 none, 01 TLB miss, 10 entry invalid, 11 modify on clean page
- tlb_we  in  1  write one TLB entry
- tlb_index  in  IDX_W  entry to write
- tlb_vpn  in  20  virtual page number
- tlb_asid  in  ASID_W  entry ASID
- tlb_g  in  1  global (ignore ASID)
- tlb_pfn  in  20  physical frame number
- tlb_v  in  1  valid bit
- tlb_d  in  1  dirty (writable) bit
- tlb_c  in  1  cacheable bit
- miss_count  out  16  saturating count of responses with rsp_exc=01

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: rsp_valid=0, rsp_paddr=0, rsp_cached=0, rsp_exc=00, miss_count=0, and every TLB slot-present flag is cleared. Entry fields are don't-care after reset.
- Pipeline:
  - Single registered stage, latency 1: a request accepted at edge N has its response visible after edge N.
  - req_ready = !rsp_valid || rsp_ready, combinational, no bubble. Full throughput is 1 request/cycle.
  - While rsp_valid && !rsp_ready, all rsp_* outputs hold stable and req_ready=0.
  - rsp_valid clears on the edge where rsp_ready=1 and no new request is accepted.
- Segment decode, on req_vaddr:
  - 0xA000_0000–0xBFFF_FFFF (kseg1): paddr = vaddr − 0xA000_0000, cached=0, exc=00. No TLB lookup.
  - 0x8000_0000–0x9FFF_FFFF (kseg0): paddr = vaddr − 0x8000_0000, cached = k0_cached sampled at acceptance, exc=00.
  - All other addresses (kuseg, kseg2/3) are mapped through the TLB.
- TLB match: entry i matches when present[i] && vpn[i]==vaddr[31:12] && (g[i] || asid[i]==req_asid).
  - Multiple matches: the lowest index wins.
- Mapped results:
  - Hit: paddr = {pfn, vaddr[11:0]}, cached=c.
  - Hit with exc: exc=10 if !v; else exc=11 if req_write && !d; else exc=00.
  - Hit with exc≠00: paddr and cached still report the entry's values.
  - Miss: exc=01, paddr=0, cached=0.
- TLB write:
  - On tlb_we, entry tlb_index is written and present set at the edge.
  - A lookup accepted in the same cycle sees the pre-write contents.
  - Writes are independent of the handshake and are allowed during backpressure; a held response is not recomputed.
- miss_count: increments by 1 on each accepted request whose result is exc=01. It saturates at 0xFFFF and never wraps.
- Reset mid-operation: a pending response is dropped (rsp_valid=0) and the TLB becomes empty. Requests presented in the reset cycle are not accepted.
- Width rules: segment subtraction is 32-bit unsigned and never underflows inside its window. Boundaries 0x7FFF_FFFF and 0xC000_0000 are TLB-mapped.

Test Plan:
- Reset, then request vaddr=0xA000_1234 → next cycle rsp_valid=1, paddr=0x0000_1234, cached=0, exc=00.
- k0_cached=1 with 0x9FFF_FFFC, then k0_cached=0 with 0x8000_0000 → paddr 0x1FFF_FFFC cached=1, then paddr 0x0000_0000 cached=0.
- Write entry 3: vpn=0x00400, asid=5, g=0, pfn=0x12345, v=1, d=0, c=1. Read 0x0040_0ABC asid=5 → paddr 0x1234_5ABC, exc=00. Same address with asid=6 → exc=01. Write with asid=5 → exc=11.
- Entries 1 and 6 both match with different pfn → entry 1 pfn used. tlb_we to index 1 in the same cycle as a request → old pfn returned, new pfn returned on the next request.
- Back-to-back requests with rsp_ready=0 for 3 cycles → req_ready=0, rsp outputs stable; on release the next response appears one cycle later with no loss or duplication.
- Preload miss_count near saturation via 65,540 misses → miss_count=0xFFFF. Assert rst during a held response → rsp_valid=0 and miss_count=0 next cycle, and a prior hit address now returns exc=01.
